// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the RV32 operand-forwarding stage: datapath widths,
// the load-use stall/replay state encoding, the per-operand source select
// encoding and the priority function that maps qualified forwarding
// conditions onto a source select.
package pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    STALL  = 2'd1,
    REPLAY = 2'd2
  } fwd_state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_REG  = 2'd1,
    SEL_MEM  = 2'd2,
    SEL_WB   = 2'd3
  } fwd_sel_t;

  // Priority: x0 hardwired zero, then the replay override (load data now in
  // the WB copy), then the younger MEM producer, then WB, else register file.
  function automatic fwd_sel_t fwd_select(input logic addr_zero,
                                          input logic replay_ovr,
                                          input logic fwd_mem,
                                          input logic fwd_wb);
    fwd_sel_t sel;
    if (addr_zero) begin
      sel = SEL_ZERO;
    end else if (replay_ovr) begin
      sel = SEL_WB;
    end else if (fwd_mem) begin
      sel = SEL_MEM;
    end else if (fwd_wb) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forward_operand_select_if.sv
// forward_operand_select_if
// Bundles the pipeline-facing signals of the operand-forwarding stage.
//   master : pipeline / hazard unit side (drives sources, reads operands, stall)
//   slave  : forwarding stage side
// Signals: four hazard-unit forward enables, ALU-stage source addresses and
// register data, ALU result with reg_write/is_load flags, MEM-stage result,
// selected operands and the stall request.
interface forward_operand_select_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  forward_enable_to_rs1_from_mem_stage_signal;
  logic                  forward_enable_to_rs2_from_mem_stage_signal;
  logic                  forward_enable_to_rs1_from_wb_stage_signal;
  logic                  forward_enable_to_rs2_from_wb_stage_signal;
  logic [REG_ADDR_W-1:0] rs1_address_alu_stage;
  logic [REG_ADDR_W-1:0] rs2_address_alu_stage;
  logic [XLEN-1:0]       rs1_data_alu_stage;
  logic [XLEN-1:0]       rs2_data_alu_stage;
  logic [XLEN-1:0]       alu_result_alu_stage;
  logic                  reg_write_alu_stage;
  logic                  is_load_alu_stage;
  logic [XLEN-1:0]       mem_result_mem_stage;
  logic [XLEN-1:0]       operand1_out;
  logic [XLEN-1:0]       operand2_out;
  logic                  stall_signal;

  modport master (
    output forward_enable_to_rs1_from_mem_stage_signal,
    output forward_enable_to_rs2_from_mem_stage_signal,
    output forward_enable_to_rs1_from_wb_stage_signal,
    output forward_enable_to_rs2_from_wb_stage_signal,
    output rs1_address_alu_stage,
    output rs2_address_alu_stage,
    output rs1_data_alu_stage,
    output rs2_data_alu_stage,
    output alu_result_alu_stage,
    output reg_write_alu_stage,
    output is_load_alu_stage,
    output mem_result_mem_stage,
    input  operand1_out,
    input  operand2_out,
    input  stall_signal
  );

  modport slave (
    input  forward_enable_to_rs1_from_mem_stage_signal,
    input  forward_enable_to_rs2_from_mem_stage_signal,
    input  forward_enable_to_rs1_from_wb_stage_signal,
    input  forward_enable_to_rs2_from_wb_stage_signal,
    input  rs1_address_alu_stage,
    input  rs2_address_alu_stage,
    input  rs1_data_alu_stage,
    input  rs2_data_alu_stage,
    input  alu_result_alu_stage,
    input  reg_write_alu_stage,
    input  is_load_alu_stage,
    input  mem_result_mem_stage,
    output operand1_out,
    output operand2_out,
    output stall_signal
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
// Source selection for one ALU operand: priority encoder followed by a 4:1
// mux over {zero, register file, MEM copy, WB copy}.
// Ports:
//   addr_zero  in  source register is x0
//   replay_ovr in  replay override active for this operand
//   fwd_mem    in  qualified MEM-stage forward
//   fwd_wb     in  qualified WB-stage forward
//   reg_data, mem_data, wb_data  in  candidate values
//   operand    out selected operand
module operand_fwd_mux
  import pipeline_pkg::*;
#(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic            addr_zero,
  input  logic            replay_ovr,
  input  logic            fwd_mem,
  input  logic            fwd_wb,
  input  logic [XLEN-1:0] reg_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  fwd_sel_t sel_s;

  // Encode the winning source for this operand.
  always_comb begin
    sel_s = fwd_select(addr_zero, replay_ovr, fwd_mem, fwd_wb);
  end

  // Steer the selected source onto the operand.
  always_comb begin
    operand = {XLEN{1'b0}};
    case (sel_s)
      SEL_ZERO: operand = {XLEN{1'b0}};
      SEL_REG:  operand = reg_data;
      SEL_MEM:  operand = mem_data;
      SEL_WB:   operand = wb_data;
      default:  operand = reg_data;
    endcase
  end

endmodule

// File: rtl/forward_operand_select.sv
// forward_operand_select
// Operand-forwarding stage of the RV32 pipeline. Keeps one-deep copies of the
// ALU-stage and MEM-stage results, qualifies the hazard unit's forward
// enables, selects both ALU operands and runs a one-bubble stall/replay
// sequence on load-use hazards.
// Ports:
//   clk    in  pipeline clock, all state updates on posedge
//   reset  in  asynchronous active-low reset
//   bus    slave modport carrying enables, sources, operands and stall_signal
module forward_operand_select
  import pipeline_pkg::*;
#(
  parameter int XLEN       = pipeline_pkg::XLEN,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  forward_operand_select_if.slave  bus
);

  logic [XLEN-1:0] mem_fwd_r;
  logic            mem_wr_r;
  logic            mem_load_r;
  logic [XLEN-1:0] wb_fwd_r;
  logic            wb_wr_r;

  fwd_state_t      state_r;
  fwd_state_t      state_next_s;
  logic            ovr1_r;
  logic            ovr2_r;
  logic            ovr1_next_s;
  logic            ovr2_next_s;

  logic            rs1_zero_s;
  logic            rs2_zero_s;
  logic            fm1_s;
  logic            fm2_s;
  logic            fw1_s;
  logic            fw2_s;
  logic            hazard_s;
  logic            stall_s;
  logic            replay_s;

  // Result copies advance every edge, including while stalled: the STALL
  // edge is exactly the one that brings the load data into the WB copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_fwd_r  <= {XLEN{1'b0}};
      mem_wr_r   <= 1'b0;
      mem_load_r <= 1'b0;
      wb_fwd_r   <= {XLEN{1'b0}};
      wb_wr_r    <= 1'b0;
    end else begin
      mem_fwd_r  <= bus.alu_result_alu_stage;
      mem_wr_r   <= bus.reg_write_alu_stage;
      mem_load_r <= bus.is_load_alu_stage;
      wb_fwd_r   <= bus.mem_result_mem_stage;
      wb_wr_r    <= mem_wr_r;
    end
  end

  // Qualify hazard-unit enables: x0 never forwards, nor does a non-writing producer.
  always_comb begin
    rs1_zero_s = (bus.rs1_address_alu_stage == {REG_ADDR_W{1'b0}});
    rs2_zero_s = (bus.rs2_address_alu_stage == {REG_ADDR_W{1'b0}});
    fm1_s      = bus.forward_enable_to_rs1_from_mem_stage_signal & mem_wr_r & ~rs1_zero_s;
    fm2_s      = bus.forward_enable_to_rs2_from_mem_stage_signal & mem_wr_r & ~rs2_zero_s;
    fw1_s      = bus.forward_enable_to_rs1_from_wb_stage_signal  & wb_wr_r  & ~rs1_zero_s;
    fw2_s      = bus.forward_enable_to_rs2_from_wb_stage_signal  & wb_wr_r  & ~rs2_zero_s;
    hazard_s   = (fm1_s | fm2_s) & mem_load_r;
  end

  // FSM state and replay overrides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= NORMAL;
      ovr1_r  <= 1'b0;
      ovr2_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ovr1_r  <= ovr1_next_s;
      ovr2_r  <= ovr2_next_s;
    end
  end

  // Next state: hazards are only acted on from NORMAL, so stall can never
  // be asserted on two consecutive cycles.
  always_comb begin
    state_next_s = NORMAL;
    ovr1_next_s  = 1'b0;
    ovr2_next_s  = 1'b0;
    case (state_r)
      NORMAL: begin
        if (hazard_s) begin
          state_next_s = STALL;
          ovr1_next_s  = fm1_s;
          ovr2_next_s  = fm2_s;
        end else begin
          state_next_s = NORMAL;
        end
      end
      STALL: begin
        state_next_s = REPLAY;
        ovr1_next_s  = ovr1_r;
        ovr2_next_s  = ovr2_r;
      end
      REPLAY: begin
        state_next_s = NORMAL;
      end
      default: begin
        state_next_s = NORMAL;
      end
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    stall_s  = 1'b0;
    replay_s = 1'b0;
    case (state_r)
      NORMAL:  stall_s = 1'b0;
      STALL:   stall_s = 1'b1;
      REPLAY:  replay_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  assign bus.stall_signal = stall_s;

  // Overrides are latched on entry to STALL but only steer operands in REPLAY.
  operand_fwd_mux #(.XLEN(XLEN)) u_op1_mux (
    .addr_zero  (rs1_zero_s),
    .replay_ovr (ovr1_r & replay_s),
    .fwd_mem    (fm1_s),
    .fwd_wb     (fw1_s),
    .reg_data   (bus.rs1_data_alu_stage),
    .mem_data   (mem_fwd_r),
    .wb_data    (wb_fwd_r),
    .operand    (bus.operand1_out)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_op2_mux (
    .addr_zero  (rs2_zero_s),
    .replay_ovr (ovr2_r & replay_s),
    .fwd_mem    (fm2_s),
    .fwd_wb     (fw2_s),
    .reg_data   (bus.rs2_data_alu_stage),
    .mem_data   (mem_fwd_r),
    .wb_data    (wb_fwd_r),
    .operand    (bus.operand2_out)
  );

endmodule
